axi4_mem_responder: RTL and testbench
=====================================

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, AXI address width
  DATA_W, 512, AXI data width; one beat = 64 bytes
  ID_W, 4, AXI ID width
  DEPTH, 1024, memory depth in DATA_W words
  BASE_ADDR, 32'h8000_0000, first decoded byte address
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all logic on posedge
  reset_n  in  1  asynchronous, active-low reset
  awid/awaddr/awlen/awvalid  in  ID_W/ADDR_W/8/1  write address channel; awready  out  1
  wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel; wready  out  1
  bid/bresp/bvalid  out  ID_W/2/1  write response channel; bready  in  1
  arid/araddr/arlen/arvalid  in  ID_W/ADDR_W/8/1  read address channel; arready  out  1
  rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel; rready  in  1
REQ-003 Burst type SHALL be INCR; size SHALL be full width. The block has no awsize, awburst, arsize or arburst ports.

Function
REQ-004 Write FSM SHALL have the states W_IDLE, W_DATA and W_RESP. awready=1 only in W_IDLE. An AW handshake SHALL capture id, address and len, and SHALL move the FSM to W_DATA.
REQ-005 In W_DATA, wready=1. Each W handshake SHALL write the bytes whose wstrb bit is set to the word at index ((addr-BASE_ADDR)>>6)+beat. The beat counter SHALL be 8-bit and SHALL increment per beat.
REQ-006 The FSM SHALL leave W_DATA when wlast=1, or when the beat count reaches len+1, whichever comes first. Either condition without the other SHALL set bresp=SLVERR; surplus beats SHALL be dropped and not written.
REQ-007 A beat whose word index is >= DEPTH, or whose address is below BASE_ADDR, SHALL NOT be written. That beat SHALL set bresp=DECERR. DECERR SHALL override SLVERR, and SLVERR SHALL override OKAY.
REQ-008 In W_RESP, bvalid=1 and bid=captured id. bvalid/bid/bresp SHALL stay stable until bready. The FSM SHALL return to W_IDLE on the cycle after the handshake.
REQ-009 Read FSM SHALL have the states R_IDLE, R_FETCH and R_DATA. arready=1 only in R_IDLE. An AR handshake SHALL capture id, address and len, and SHALL move the FSM to R_FETCH.
REQ-010 R_FETCH SHALL issue a registered RAM read and go to R_DATA, so the first rvalid comes 2 cycles after the AR handshake. In R_DATA, rvalid=1, and rdata/rresp/rlast/rid SHALL stay stable until rready.
REQ-011 On an R handshake that is not the last beat, the FSM SHALL go to R_FETCH for the next beat (at most one beat every 2 cycles). On the beat with rlast=1 it SHALL go to R_IDLE.
REQ-012 rlast=1 only on beat len. An out-of-range beat SHALL return rdata=0 and rresp=DECERR; all other beats SHALL return OKAY.
REQ-013 The read and write FSMs SHALL run independently. A read and a write to the same word in the same cycle SHALL return the old data (read-first).
REQ-014 Address bits [5:0] SHALL be ignored. Word index arithmetic SHALL be done at ADDR_W width with no wrap; a beat past the end of memory SHALL be DECERR.

Reset
REQ-015 While reset_n=0: awready, wready, bvalid, arready, rvalid and rlast SHALL be 0; bresp, rresp, bid, rid and rdata SHALL be 0; both FSMs SHALL be in their idle state.
REQ-016 Assertion of reset mid-burst SHALL abandon the transaction with no response. Memory contents SHALL NOT be reset. The first AW/AR SHALL be accepted no earlier than the first clk edge after reset_n rises.

Structure
REQ-017 Package axi4_mem_pkg SHALL hold the resp typedef (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), the W/R state enums, and the beat size constant (64 bytes).
REQ-018 The memory SHALL be one sub-module, mem_bram_be: 1 write port and 1 read port, per-byte enables, 1-cycle registered read.

Verification
REQ-019 Bench scenarios SHALL be:
  Write len=0 at 0x8000_0000 with wdata=512'hdeadbeaf and full strobe, then read len=0 -> bresp=OKAY, rdata=512'hdeadbeaf, rlast=1, rresp=OKAY.
  Write len=3 at 0x8000_0040 with beats k=1..4, then read len=3 -> 4 beats returning 1..4, rlast only on the 4th, rid=awid=4'h5.
  wstrb=64'h1 writing 8'hAA over an old word of 0 -> read returns 512'hAA.
  awaddr=0x0000_1000 -> bresp=DECERR; read of the same address -> rdata=0, rresp=DECERR.
  bready and rready held low for 10 cycles -> bvalid/rvalid held with stable payload; no second AW/AR accepted.
  wlast on beat 1 of len=3 -> bresp=SLVERR. Separately, reset_n pulsed low mid-burst -> all valids=0, FSMs idle, next transaction completes OKAY.

Source files
------------

// File: rtl/axi4_mem_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : axi4_mem_pkg
// Brief  : Shared response codes, FSM state encodings and beat geometry.
// Rev    : 1.0
// -----------------------------------------------------------------------------
package axi4_mem_pkg;

   localparam int BEAT_BYTES = 64;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_FETCH = 2'd1,
      R_DATA  = 2'd2
   } r_state_e;

   // DECERR dominates SLVERR, which dominates OKAY.
   function automatic resp_e resp_merge(input resp_e a, input resp_e b);
      if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
      if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bram_be.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : mem_bram_be
// Brief  : Simple dual-port RAM, per-byte write enables, registered read-first.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module mem_bram_be #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 1024,
   localparam int AW    = $clog2(DEPTH),
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Non-blocking write means a same-cycle read sees the previous contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) r_mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (rd_en) r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axi4_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : axi4_mem_responder
// Brief  : AXI4 INCR full-width memory slave with independent read/write FSMs.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module axi4_mem_responder
   import axi4_mem_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 512,
   parameter int                ID_W      = 4,
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);

   localparam int                MEM_AW      = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH);

   // Write channel state
   w_state_e          r_w_state;
   logic [ID_W-1:0]   r_w_id;
   logic [ADDR_W-1:0] r_w_addr;
   logic [7:0]        r_w_len;
   logic [7:0]        r_w_beat;
   resp_e             r_w_resp;
   resp_e             r_bresp;
   logic              r_awready;
   logic              r_wready;
   logic              r_bvalid;

   // Read channel state
   r_state_e          r_r_state;
   logic [ID_W-1:0]   r_r_id;
   logic [ADDR_W-1:0] r_r_addr;
   logic [7:0]        r_r_len;
   logic [7:0]        r_r_beat;
   resp_e             r_rresp;
   logic              r_arready;
   logic              r_rvalid;
   logic              r_rlast;
   logic              r_rd_oob;

   logic [ADDR_W-1:0] w_wr_idx;
   logic [ADDR_W-1:0] w_rd_idx;
   logic              w_wr_oob;
   logic              w_rd_oob;
   logic              w_wbeat_hs;
   logic              w_wr_len_done;
   resp_e             w_beat_resp;
   logic [DATA_W-1:0] w_mem_rdata;

   // Base is beat aligned, so the shift discards address bits [5:0].
   always_comb begin
      w_wr_idx = ((r_w_addr - BASE_ADDR) >> BEAT_SHIFT) + ADDR_W'(r_w_beat);
      w_rd_idx = ((r_r_addr - BASE_ADDR) >> BEAT_SHIFT) + ADDR_W'(r_r_beat);
      w_wr_oob = (r_w_addr < BASE_ADDR) || (w_wr_idx >= DEPTH_WORDS);
      w_rd_oob = (r_r_addr < BASE_ADDR) || (w_rd_idx >= DEPTH_WORDS);
   end

   always_comb begin
      w_wbeat_hs    = wvalid && r_wready;
      w_wr_len_done = (r_w_beat == r_w_len);
      w_beat_resp   = RESP_OKAY;
      if (w_wr_oob)                    w_beat_resp = RESP_DECERR;
      else if (wlast != w_wr_len_done) w_beat_resp = RESP_SLVERR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_w_state <= W_IDLE;
         r_w_id    <= '0;
         r_w_addr  <= '0;
         r_w_len   <= '0;
         r_w_beat  <= '0;
         r_w_resp  <= RESP_OKAY;
         r_bresp   <= RESP_OKAY;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         unique case (r_w_state)
            W_IDLE: begin
               r_awready <= 1'b1;
               if (awvalid && r_awready) begin
                  r_w_id    <= awid;
                  r_w_addr  <= awaddr;
                  r_w_len   <= awlen;
                  r_w_beat  <= '0;
                  r_w_resp  <= RESP_OKAY;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_wbeat_hs) begin
                  r_w_beat <= r_w_beat + 8'd1;
                  r_w_resp <= resp_merge(r_w_resp, w_beat_resp);
                  if (wlast || w_wr_len_done) begin
                     r_bresp   <= resp_merge(r_w_resp, w_beat_resp);
                     r_wready  <= 1'b0;
                     r_bvalid  <= 1'b1;
                     r_w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_w_state <= W_IDLE;
               end
            end
            default: r_w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_r_state <= R_IDLE;
         r_r_id    <= '0;
         r_r_addr  <= '0;
         r_r_len   <= '0;
         r_r_beat  <= '0;
         r_rresp   <= RESP_OKAY;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rd_oob  <= 1'b0;
      end else begin
         unique case (r_r_state)
            R_IDLE: begin
               r_arready <= 1'b1;
               if (arvalid && r_arready) begin
                  r_r_id    <= arid;
                  r_r_addr  <= araddr;
                  r_r_len   <= arlen;
                  r_r_beat  <= '0;
                  r_arready <= 1'b0;
                  r_r_state <= R_FETCH;
               end
            end
            R_FETCH: begin
               r_rvalid  <= 1'b1;
               r_rlast   <= (r_r_beat == r_r_len);
               r_rresp   <= w_rd_oob ? RESP_DECERR : RESP_OKAY;
               r_rd_oob  <= w_rd_oob;
               r_r_state <= R_DATA;
            end
            R_DATA: begin
               if (rready) begin
                  r_rvalid <= 1'b0;
                  r_rlast  <= 1'b0;
                  if (r_rlast) begin
                     r_arready <= 1'b1;
                     r_r_state <= R_IDLE;
                  end else begin
                     r_r_beat  <= r_r_beat + 8'd1;
                     r_r_state <= R_FETCH;
                  end
               end
            end
            default: r_r_state <= R_IDLE;
         endcase
      end
   end

   mem_bram_be #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_wbeat_hs && !w_wr_oob),
      .wr_addr (w_wr_idx[MEM_AW-1:0]),
      .wr_data (wdata),
      .wr_be   (wstrb),
      .rd_en   (r_r_state == R_FETCH),
      .rd_addr (w_rd_idx[MEM_AW-1:0]),
      .rd_data (w_mem_rdata)
   );

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bid     = r_w_id;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rlast;
   assign rid     = r_r_id;
   assign rresp   = r_rresp;
   // RAM output register is held between fetches; gate it so idle and
   // out-of-range beats present zero.
   assign rdata   = (r_rvalid && !r_rd_oob) ? w_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : tb_axi4_mem_responder
// Brief  : Table, hand-sequence and random checks against a byte-level model.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module tb_axi4_mem_responder;
   import axi4_mem_pkg::*;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          TO    = 100;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [3:0]   awid = '0, arid = '0, bid, rid;
   logic [31:0]  awaddr = '0, araddr = '0;
   logic [7:0]   awlen = '0, arlen = '0;
   logic         awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic [511:0] wdata = '0, rdata;
   logic [63:0]  wstrb = '0;
   logic [1:0]   bresp, rresp;
   logic         bvalid, bready = 1'b0, arvalid = 1'b0, arready;
   logic         rlast, rvalid, rready = 1'b0;

   always #5 clk = ~clk;

   axi4_mem_responder dut (
      .clk(clk), .reset_n(reset_n),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference memory: data plus a per-byte "has been written" mask.
   logic [511:0] m_data  [longint];
   logic [63:0]  m_known [longint];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got no handshake within %0d cycles, expected one", name, TO);
   endtask

   function automatic longint widx(input logic [31:0] addr, input int beat);
      if (addr < BASE) return -1;
      return longint'((addr - BASE) >> 6) + longint'(beat);
   endfunction

   function automatic bit is_oob(input longint i);
      return (i < 0) || (i >= DEPTH);
   endfunction

   function automatic logic [511:0] bytemask(input logic [63:0] m);
      logic [511:0] r;
      for (int b = 0; b < 64; b++) r[b*8 +: 8] = {8{m[b]}};
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic m_write(input longint i, input logic [511:0] d, input logic [63:0] s);
      if (!m_data.exists(i)) begin
         m_data[i]  = '0;
         m_known[i] = '0;
      end
      for (int b = 0; b < 64; b++) begin
         if (s[b]) begin
            m_data[i][b*8 +: 8] = d[b*8 +: 8];
            m_known[i][b]       = 1'b1;
         end
      end
   endtask

   // abort >= 0 stops after that many beats (no B phase); bstall holds bready low.
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int last_pos, input bit rnd, input logic [511:0] seed,
                           input logic [63:0] strb, input int bstall, input int abort,
                           output logic [1:0] got);
      int t, n;
      bit dec;
      longint i;
      logic [511:0] d;
      logic [63:0] s;
      logic [1:0] exp;
      got = 2'bxx;
      dec = 1'b0;
      @(negedge clk);
      awid = id; awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
      t = 0;
      while (!awready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) begin timeout("aw_hs"); awvalid = 1'b0; return; end
      @(negedge clk);
      awvalid = 1'b0;
      n = (last_pos < len) ? last_pos + 1 : len + 1;
      for (int k = 0; k < n; k++) begin
         if (abort == k) begin wvalid = 1'b0; wlast = 1'b0; return; end
         d = rnd ? rand512() : seed + 512'(k);
         s = rnd ? {$urandom, $urandom} : strb;
         wdata = d; wstrb = s; wlast = (k == last_pos); wvalid = 1'b1;
         t = 0;
         while (!wready && t < TO) begin @(negedge clk); t++; end
         if (t >= TO) begin timeout("w_hs"); wvalid = 1'b0; return; end
         i = widx(addr, k);
         if (is_oob(i)) dec = 1'b1;
         else m_write(i, d, s);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      exp = dec ? RESP_DECERR : (last_pos != len) ? RESP_SLVERR : RESP_OKAY;
      t = 0;
      while (!bvalid && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) begin timeout("b_valid"); return; end
      awaddr = BASE; awvalid = (bstall > 0);
      for (int c = 0; c < bstall; c++) begin
         check("b_hold_valid", bvalid, 1'b1);
         check("b_hold_resp", bresp, exp);
         check("b_hold_id", bid, id);
         check("b_hold_awready", awready, 1'b0);
         @(negedge clk);
      end
      awvalid = 1'b0;
      bready = 1'b1;
      got = bresp;
      check("bresp", bresp, exp);
      check("bid", bid, id);
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int rstall);
      int t;
      longint i;
      logic [511:0] ed, mask;
      logic [1:0] er;
      @(negedge clk);
      arid = id; araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
      t = 0;
      while (!arready && t < TO) begin @(negedge clk); t++; end
      if (t >= TO) begin timeout("ar_hs"); arvalid = 1'b0; return; end
      @(negedge clk);
      arvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         check("r_fetch_gap", rvalid, 1'b0);
         t = 0;
         while (!rvalid && t < TO) begin @(negedge clk); t++; end
         if (t >= TO) begin timeout("r_valid"); return; end
         check("r_latency", t, 1);
         i = widx(addr, k);
         if (is_oob(i)) begin
            ed = '0; mask = '1; er = RESP_DECERR;
         end else begin
            er = RESP_OKAY;
            ed = m_data.exists(i) ? m_data[i] : '0;
            mask = m_data.exists(i) ? bytemask(m_known[i]) : '0;
         end
         araddr = BASE; arvalid = (rstall > 0);
         for (int c = 0; c < rstall; c++) begin
            check("r_hold_valid", rvalid, 1'b1);
            check("r_hold_resp", rresp, er);
            check("r_hold_last", rlast, (k == len));
            check("r_hold_arready", arready, 1'b0);
            if (mask != '0) check("r_hold_data", rdata & mask, ed & mask);
            @(negedge clk);
         end
         arvalid = 1'b0;
         rready = 1'b1;
         if (mask != '0) check("rdata", rdata & mask, ed & mask);
         check("rresp", rresp, er);
         check("rlast", rlast, (k == len));
         check("rid", rid, id);
         @(negedge clk);
         rready = 1'b0;
      end
   endtask

   typedef struct {
      logic [3:0]   id;
      logic [31:0]  addr;
      int           len;
      int           last_pos;
      logic [511:0] seed;
      logic [1:0]   exp;
   } wvec_t;

   wvec_t tbl [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] got;
      int len, sel, lp;
      logic [31:0] addr;
      logic [3:0] id;

      tbl[0] = '{4'h1, 32'h8000_0000, 0, 0, 512'hdeadbeaf, RESP_OKAY};
      tbl[1] = '{4'h5, 32'h8000_0040, 3, 3, 512'h1,        RESP_OKAY};
      tbl[2] = '{4'h2, 32'h8000_0040, 3, 1, 512'h100,      RESP_SLVERR};
      tbl[3] = '{4'h3, 32'h8000_0200, 1, 5, 512'h200,      RESP_SLVERR};
      tbl[4] = '{4'h4, 32'h0000_1000, 0, 0, 512'h300,      RESP_DECERR};
      tbl[5] = '{4'h6, 32'h8000_FFC0, 1, 1, 512'h400,      RESP_DECERR};
      tbl[6] = '{4'h7, 32'h0000_2000, 2, 0, 512'h500,      RESP_DECERR};
      tbl[7] = '{4'h8, 32'h8000_007F, 0, 0, 512'h77,       RESP_OKAY};
      tbl[8] = '{4'h9, 32'hFFFF_FFC0, 0, 0, 512'h600,      RESP_DECERR};
      tbl[9] = '{4'hA, 32'h8000_FF80, 3, 3, 512'h700,      RESP_DECERR};

      repeat (3) @(negedge clk);
      check("rst_awready", awready, 1'b0);
      check("rst_wready", wready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_arready", arready, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rlast", rlast, 1'b0);
      check("rst_payload", {bresp, rresp, bid, rid}, '0);
      check("rst_rdata", rdata, '0);
      reset_n = 1'b1;
      #1 check("rst_release_awready", awready, 1'b0);

      for (int v = 0; v < 10; v++) begin
         do_write(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].last_pos, 1'b0,
                  tbl[v].seed, '1, 0, -1, got);
         check("bresp_table", got, tbl[v].exp);
         do_read(tbl[v].id, tbl[v].addr, tbl[v].len, 0);
      end

      // Single-byte strobe over a zeroed word.
      do_write(4'h1, 32'h8000_0400, 0, 0, 1'b0, '0, '1, 0, -1, got);
      do_write(4'h1, 32'h8000_0400, 0, 0, 1'b0, 512'hAA, 64'h1, 0, -1, got);
      do_read(4'h1, 32'h8000_0400, 0, 0);
      check("strobe_byte0", m_data[16], 512'hAA);

      // Back-pressure on B and R.
      do_write(4'hC, 32'h8000_0440, 1, 1, 1'b1, '0, '1, 10, -1, got);
      do_read(4'hC, 32'h8000_0440, 1, 10);

      // Reset in the middle of a write burst and a read burst.
      do_write(4'h3, 32'h8000_0800, 3, 3, 1'b1, '0, '1, 0, 2, got);
      @(negedge clk);
      arid = 4'h3; araddr = 32'h8000_0040; arlen = 8'd3; arvalid = 1'b1;
      while (!arready) @(negedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      check("mid_rd_rvalid", rvalid, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mr_awready", awready, 1'b0);
      check("mr_wready", wready, 1'b0);
      check("mr_bvalid", bvalid, 1'b0);
      check("mr_arready", arready, 1'b0);
      check("mr_rvalid", rvalid, 1'b0);
      check("mr_rlast", rlast, 1'b0);
      check("mr_rdata", rdata, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1 check("mr_release_arready", arready, 1'b0);
      do_write(4'hD, 32'h8000_0900, 1, 1, 1'b0, 512'h900, '1, 0, -1, got);
      check("post_reset_bresp", got, RESP_OKAY);
      do_read(4'hD, 32'h8000_0900, 1, 0);
      do_read(4'h3, 32'h8000_0800, 3, 0);

      // Independent channels running together.
      fork
         do_write(4'hE, 32'h8000_0A00, 3, 3, 1'b1, '0, '1, 0, -1, got);
         do_read(4'h5, 32'h8000_0040, 3, 0);
      join

      for (int r = 0; r < 25; r++) begin
         len = $urandom_range(0, 3);
         sel = $urandom_range(0, 9);
         if (sel < 7)       addr = BASE + 32'($urandom_range(0, 24) * 64 + $urandom_range(0, 63));
         else if (sel == 7) addr = BASE + 32'((DEPTH - 2) * 64);
         else if (sel == 8) addr = 32'($urandom_range(0, 32'h7FFF_FFFF));
         else               addr = BASE + 32'(DEPTH * 64) + 32'($urandom_range(0, 4095));
         lp = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : len;
         id = 4'($urandom);
         do_write(id, addr, len, lp, 1'b1, '0, '1, 0, -1, got);
         do_read(id, addr, len, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
